// File: rtl/yb_lane_serializer.sv
// yb_lane_serializer: accepts an X*Y-bit word over valid/ready and replays it as Y
// X-bit lanes, lane 0 first, with a saturating count of completed words.
module yb_lane_serializer #(
    parameter int unsigned X = 4,
    parameter int unsigned Y = 1,
    localparam int unsigned BW = (Y > 1) ? $clog2(Y) : 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [X*Y-1:0]   yb,
    input  logic             yb_valid,
    input  logic             yb_last,
    output logic             yb_ready,
    output logic [X-1:0]     lane_data,
    output logic             lane_valid,
    input  logic             lane_ready,
    output logic             lane_first,
    output logic             lane_last,
    output logic [BW-1:0]    lane_idx,
    input  logic             cnt_clr,
    output logic [15:0]      word_cnt
);

    typedef enum logic {StIdle = 1'b0, StBusy = 1'b1} state_e;

    localparam logic [BW-1:0] LastIdx = BW'(Y - 1);

    state_e         state_q, state_d;
    logic [BW-1:0]  idx_q, idx_d;
    logic           last_q, last_d;
    logic [X*Y-1:0] word_q, word_d;
    logic [15:0]    word_cnt_q;

    logic           busy, at_end, fire, fin, acc;
    logic [X*Y-1:0] shifted;

    // Handshake decode; yb_ready looks through lane_ready so words flow without a bubble.
    always_comb begin
        busy     = (state_q == StBusy);
        at_end   = (idx_q == LastIdx);
        fire     = busy && lane_ready;
        fin      = fire && at_end;
        yb_ready = !busy || fin;
        acc      = yb_valid && yb_ready;
    end

    // Next-state: load on accept, advance on each fired beat, drop to idle after the last.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        word_d  = word_q;
        if (acc) begin
            word_d  = yb;
            last_d  = yb_last;
            idx_d   = '0;
            state_d = StBusy;
        end else if (fin) begin
            idx_d   = '0;
            state_d = StIdle;
        end else if (fire) begin
            idx_d   = idx_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            word_q  <= word_d;
        end
    end

    // Completed-word counter; clear takes priority over an increment in the same cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            word_cnt_q <= '0;
        end else if (cnt_clr) begin
            word_cnt_q <= '0;
        end else if (fin && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    // Lane outputs come only from registers, so yb/yb_valid never reach them combinationally.
    always_comb begin
        shifted    = word_q >> (idx_q * X);
        lane_valid = busy;
        lane_data  = busy ? shifted[X-1:0] : '0;
        lane_idx   = idx_q;
        lane_first = busy && (idx_q == '0);
        lane_last  = busy && at_end && last_q;
        word_cnt   = word_cnt_q;
    end

endmodule

// File: tb/tb_yb_lane_serializer.sv
// Bench for yb_lane_serializer: a 4x3 instance and an 8x1 instance, each with a
// scoreboard of expected beats filled as words are driven and drained on each fired beat.
module tb_yb_lane_serializer;

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: X=4, Y=3
    logic [11:0] a_yb;
    logic        a_valid, a_last, a_yb_ready, a_lane_valid, a_lane_ready;
    logic        a_first, a_lane_last, a_clr;
    logic [3:0]  a_data;
    logic [1:0]  a_idx;
    logic [15:0] a_cnt;

    // Instance B: X=8, Y=1
    logic [7:0]  b_yb;
    logic        b_valid, b_last, b_yb_ready, b_lane_valid, b_lane_ready;
    logic        b_first, b_lane_last, b_clr;
    logic [7:0]  b_data;
    logic [0:0]  b_idx;
    logic [15:0] b_cnt;

    logic [31:0] a_q[$];
    logic [31:0] b_q[$];

    yb_lane_serializer #(.X(4), .Y(3)) u_a (
        .clk(clk), .rstb(rstb), .yb(a_yb), .yb_valid(a_valid), .yb_last(a_last),
        .yb_ready(a_yb_ready), .lane_data(a_data), .lane_valid(a_lane_valid),
        .lane_ready(a_lane_ready), .lane_first(a_first), .lane_last(a_lane_last),
        .lane_idx(a_idx), .cnt_clr(a_clr), .word_cnt(a_cnt)
    );

    yb_lane_serializer #(.X(8), .Y(1)) u_b (
        .clk(clk), .rstb(rstb), .yb(b_yb), .yb_valid(b_valid), .yb_last(b_last),
        .yb_ready(b_yb_ready), .lane_data(b_data), .lane_valid(b_lane_valid),
        .lane_ready(b_lane_ready), .lane_first(b_first), .lane_last(b_lane_last),
        .lane_idx(b_idx), .cnt_clr(b_clr), .word_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat for A packed as {idx, first, last, data}.
    task automatic put_a(input logic [11:0] w, input logic last);
        bit ok;
        for (int k = 0; k < 3; k++) begin
            logic [1:0] ki;
            ki = 2'(k);
            a_q.push_back({24'd0, ki, (k == 0), ((k == 2) && last), w[k*4 +: 4]});
        end
        a_yb    = w;
        a_last  = last;
        a_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = a_yb_ready;
        end
        chk("a_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Expected beat for B packed as {first, last, idx, data}.
    function automatic logic [31:0] exp_b(input logic [7:0] d, input logic last);
        return {21'd0, 1'b1, last, 1'b0, d};
    endfunction

    // Monitor A: every fired beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstb && a_lane_valid && a_lane_ready) begin
            if (a_q.size() == 0) begin
                chk("a_extra_beat", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = a_q.pop_front();
                chk("a_beat", {24'd0, a_idx, a_first, a_lane_last, a_data}, e);
            end
        end
    end

    // Monitor B: beats against scoreboard, and yb_ready tracks lane_ready || idle.
    always @(negedge clk) begin
        if (rstb) begin
            chk("b_yb_ready", 32'(b_yb_ready), 32'(b_lane_ready || !b_lane_valid));
            if (b_lane_valid && b_lane_ready) begin
                if (b_q.size() == 0) begin
                    chk("b_extra_beat", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = b_q.pop_front();
                    chk("b_beat", {21'd0, b_first, b_lane_last, b_idx, b_data}, e);
                end
            end
        end
    end

    initial begin
        rstb = 1'b0;
        a_yb = '0; a_valid = 0; a_last = 0; a_lane_ready = 1; a_clr = 0;
        b_yb = '0; b_valid = 0; b_last = 0; b_lane_ready = 1; b_clr = 0;
        #1;
        chk("rst_valid", 32'(a_lane_valid), 32'd0);
        chk("rst_ready", 32'(a_yb_ready), 32'd1);
        chk("rst_outs", {a_data, a_idx, a_first, a_lane_last}, 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk); #1;

        // Basic serialization
        put_a(12'hCBA, 1'b1);
        a_valid = 0;
        @(negedge clk);
        chk("basic_cnt0", 32'(a_cnt), 32'd0);
        chk("basic_busy_ready", 32'(a_yb_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("basic_fin_ready", 32'(a_yb_ready), 32'd1);
        @(negedge clk);
        chk("basic_cnt1", 32'(a_cnt), 32'd1);
        chk("basic_idle", 32'(a_lane_valid), 32'd0);

        // Backpressure during beat 1
        @(posedge clk); #1;
        put_a(12'hCBA, 1'b1);
        a_valid = 0;
        @(posedge clk); #1;
        a_lane_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_data", 32'(a_data), 32'hB);
            chk("bp_idx", 32'(a_idx), 32'd1);
            chk("bp_valid", 32'(a_lane_valid), 32'd1);
            chk("bp_ready", 32'(a_yb_ready), 32'd0);
        end
        @(posedge clk); #1;
        a_lane_ready = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle", 32'(a_lane_valid), 32'd0);
        chk("bp_cnt", 32'(a_cnt), 32'd2);

        // Back-to-back words, no bubble
        @(posedge clk); #1;
        put_a(12'h321, 1'b0);
        put_a(12'h654, 1'b1);
        a_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_no_bubble", 32'(a_lane_valid), 32'd1);
        end
        @(negedge clk);
        chk("b2b_idle", 32'(a_lane_valid), 32'd0);
        chk("b2b_cnt", 32'(a_cnt), 32'd4);
        chk("b2b_q_empty", 32'(a_q.size()), 32'd0);

        // Reset mid-word, right after beat 0 fires
        @(posedge clk); #1;
        put_a(12'hCBA, 1'b1);
        a_valid = 0;
        @(posedge clk); #1;
        rstb = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_lane_valid), 32'd0);
        chk("mid_rst_data", 32'(a_data), 32'd0);
        chk("mid_rst_cnt", 32'(a_cnt), 32'd0);
        chk("mid_rst_ready", 32'(a_yb_ready), 32'd1);
        chk("mid_rst_q", 32'(a_q.size()), 32'd2);
        a_q.delete();
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk); #1;
        put_a(12'hFED, 1'b1);
        a_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_cnt", 32'(a_cnt), 32'd1);
        chk("post_rst_q_empty", 32'(a_q.size()), 32'd0);

        // Y=1 streaming with lane_ready 1,0,1,1
        @(posedge clk); #1;
        b_last = 1; b_valid = 1; b_yb = 8'h11; b_q.push_back(exp_b(8'h11, 1'b1));
        @(posedge clk); #1;
        b_yb = 8'h22; b_q.push_back(exp_b(8'h22, 1'b1)); b_lane_ready = 0;
        @(posedge clk); #1;
        b_lane_ready = 1;
        @(posedge clk); #1;
        b_yb = 8'h33; b_q.push_back(exp_b(8'h33, 1'b1));
        @(posedge clk); #1;
        b_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("y1_q_empty", 32'(b_q.size()), 32'd0);
        chk("y1_cnt", 32'(b_cnt), 32'd3);

        // Counter saturation: bring word_cnt to FFFE, then past the top
        @(posedge clk); #1;
        b_last = 0; b_valid = 1;
        for (int i = 0; i < 65531; i++) begin
            b_yb = 8'(i);
            b_q.push_back(exp_b(8'(i), 1'b0));
            @(posedge clk); #1;
        end
        b_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("cnt_fffe", 32'(b_cnt), 32'hFFFE);
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            b_valid = 1; b_yb = 8'hA0 + 8'(n); b_q.push_back(exp_b(8'hA0 + 8'(n), 1'b0));
            if (n == 1) begin
                @(posedge clk); #1;
                b_yb = 8'hA5; b_q.push_back(exp_b(8'hA5, 1'b0));
            end
            @(posedge clk); #1;
            b_valid = 0;
            @(posedge clk);
            @(negedge clk);
            chk("cnt_sat", 32'(b_cnt), 32'hFFFF);
        end

        // Clear in the same cycle as fin: clear wins
        @(posedge clk); #1;
        b_valid = 1; b_yb = 8'h5A; b_q.push_back(exp_b(8'h5A, 1'b0));
        @(posedge clk); #1;
        b_valid = 0; b_clr = 1;
        @(posedge clk); #1;
        b_clr = 0;
        @(negedge clk);
        chk("clr_wins", 32'(b_cnt), 32'd0);
        chk("final_b_q_empty", 32'(b_q.size()), 32'd0);
        chk("final_a_q_empty", 32'(a_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/yb_lane_serializer.md
# yb_lane_serializer

Downstream stage of `yy`. Takes the `yb` word (`X*Y` bits, Y lanes of X bits) through a valid/ready handshake and emits it one X-bit lane per beat, lane 0 first. The output stream can feed a narrow X-bit consumer. The block also keeps a saturating count of completed words for status readout.

## Interface
- `X`, default 4: lane width in bits; must be ≥1.
- `Y`, default 1: lanes per word; must be ≥1. Beat index width `BW = max(1, $clog2(Y))`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `yb`  in  X*Y  input word; lane k = `yb[k*X +: X]`.
- `yb_valid`  in  1  input word valid.
- `yb_last`  in  1  word is the last of a packet; sampled with `yb`.
- `yb_ready`  out  1  block accepts `yb` this cycle.
- `lane_data`  out  X  current lane.
- `lane_valid`  out  1  `lane_data` valid.
- `lane_ready`  in  1  consumer accepts the lane.
- `lane_first`  out  1  current beat is lane 0.
- `lane_last`  out  1  final lane of a word whose `yb_last` was 1.
- `lane_idx`  out  BW  index of the current lane.
- `cnt_clr`  in  1  synchronous clear of `word_cnt`.
- `word_cnt`  out  16  completed words, saturating.

## Operation
- State is a `busy` flag with two states. IDLE means no word held. BUSY means a word is held, with beat index `idx` and the registered `last_q`.
- Input handshake: `acc = yb_valid && yb_ready`. Output handshake: `fire = lane_valid && lane_ready`. Final beat: `fin = fire && idx == Y-1`.
- `yb_ready = !busy || fin`. This is combinational, so back-to-back words flow with no bubble.
- On `acc`:
  - register `yb` into the word register;
  - set `last_q = yb_last`, `idx = 0`, `busy = 1`.
- Transitions:
  - IDLE→BUSY on `acc`.
  - In BUSY, `fire && !fin` increments `idx`.
  - `fin && acc` reloads the word and stays BUSY.
  - `fin && !acc` returns to IDLE with `idx = 0`.
- Output decode:
  - `lane_valid = busy`;
  - `lane_data = word[idx*X +: X]`;
  - `lane_idx = idx`;
  - `lane_first = busy && idx == 0`;
  - `lane_last = busy && idx == Y-1 && last_q`.
  - `lane_data` is 0 in IDLE.
- While `lane_valid && !lane_ready`, all lane outputs hold stable.
- A `yb` change while the block is BUSY and not ready has no effect.
- Y=1: every beat is the final beat. The block is a one-deep pipeline register with full throughput.
- `word_cnt`:
  - +1 on `fin`, saturating at 16'hFFFF;
  - `cnt_clr` forces 0;
  - `cnt_clr` and `fin` in the same cycle gives 0 (clear wins).
- Reset (async assert, sync-safe deassert is the top's job):
  - `busy=0`, `idx=0`, `last_q=0`, word register 0, `word_cnt=0`.
  - Output values: `lane_valid=0`, `lane_data=0`, `lane_first=0`, `lane_last=0`, `lane_idx=0`, `yb_ready=1`.
- Reset mid-word drops the held word; no partial beats are emitted after release.

## Timing
- Accept at edge n gives lane 0 valid after edge n (visible in cycle n+1).
- Lane k is presented no earlier than cycle n+1+k.
- Full-rate throughput is one lane per cycle, so Y cycles per word with no gap between words when `lane_ready` stays 1.
- `yb_ready` depends combinationally on `lane_ready`. There is no combinational path from `yb`/`yb_valid` to any lane output.
- `word_cnt` updates at the edge of `fin` and is visible the next cycle.

## Test plan
- **Basic serialization** (X=4, Y=3, `lane_ready=1`): accept `yb=12'hCBA`, `yb_last=1`.
  - Response: `lane_data` A,B,C on 3 consecutive cycles.
  - `lane_first` on A only; `lane_last` on C only; `word_cnt` 0→1.
- **Backpressure** (X=4, Y=3): same word with `lane_ready` low for 2 cycles during beat 1.
  - Response: `lane_data=B`, `lane_idx=1` held stable; `yb_ready=0` throughout.
  - The sequence then resumes with C; total 5 cycles.
- **Back-to-back words** (X=4, Y=3): 12'h321 (`last=0`) then 12'h654 (`last=1`) held valid.
  - Response: second word accepted in the same cycle as beat 3 fires.
  - Output is 1,2,3,4,5,6 with no bubble; `lane_last` only on 6.
- **Y=1** (X=8): stream 8'h11, 8'h22, 8'h33 with `lane_ready` toggling 1,0,1,1.
  - Response: outputs 11,22,33 in order, none lost or duplicated.
  - `yb_ready` equals `lane_ready || !busy` every cycle.
- **Reset mid-word** (Y=3): assert `rstb=0` after beat 0 fires.
  - Response: immediate `lane_valid=0`, `lane_data=0`, `word_cnt=0`, `yb_ready=1`.
  - After release, the next accepted word starts at lane 0.
- **Counter boundaries**:
  - Preload `word_cnt` to 16'hFFFE by completing 65534 words (or by force), then complete 2 more: `word_cnt` stays at FFFF.
  - Assert `cnt_clr` in the same cycle as a `fin`: next cycle `word_cnt=0`.
